bloom_req_sequencer: RTL
========================

Name: bloom_req_sequencer

Overview:
- Command front end directly upstream of the Bloom filter block.
- Accepts a valid/ready stream of INSERT/CHECK/CLEAR/NOP commands carrying a key and tag.
- Drives the filter's insert/check/data/reset pins one cycle per command, honouring the filter's hash-pipeline hazards.
- Captures the filter's match result and returns it as a tagged response with valid/ready.

Parameters:
- D_SIZE, 32, key width; equals the filter data width.
- TAG_W, 4, width of the tag echoed on responses.
- INS_LAT, 2, minimum cycles from an issued insert or clear to a safe check issue.
- MATCH_LAT, 2, cycles from the bl_check pulse to a valid bl_match sample.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  2  opcode: 00 NOP, 01 INSERT, 10 CHECK, 11 CLEAR.
- cmd_key  in  D_SIZE  key.
- cmd_tag  in  TAG_W  tag for CHECK.
- bl_insert  out  1  to filter insert.
- bl_check  out  1  to filter check.
- bl_reset  out  1  to filter reset.
- bl_data  out  D_SIZE  to filter data.
- bl_match  in  1  from filter match.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_hit  out  1  sampled bl_match.
- rsp_tag  out  TAG_W  tag of the CHECK.
- stat_ins, stat_chk, stat_hit  out  CNT_W each  statistics counters.

Behaviour:
- Reset values: all outputs 0, cmd_ready 0, state IDLE, haz_cnt 0; a pending check is dropped.
- FSM states: IDLE, WAIT_MATCH, RESP.
- cmd_ready = (state==IDLE) && (haz_cnt==0 || cmd_op!=CHECK). Ready depends on cmd_op; this is intentional.
- All bl_* outputs are registered. A command accepted in cycle T drives its pulse in T+1 only. bl_data is updated on every accept and holds its value otherwise.
- INSERT: bl_insert=1 and bl_data=key in T+1; haz_cnt loads INS_LAT. Back-to-back INSERTs give one pulse per cycle.
- CLEAR: bl_reset=1 in T+1; haz_cnt loads INS_LAT.
- NOP: accepted with no pin activity.
- haz_cnt decrements to 0 while nonzero. A simultaneous load takes priority over the decrement.
- CHECK: bl_check=1 and bl_data=key in T+1. The FSM enters WAIT_MATCH with wcnt=MATCH_LAT.
  - bl_match is sampled in cycle T+1+MATCH_LAT into rsp_hit; rsp_tag=cmd_tag (latched at accept).
  - The FSM then enters RESP with rsp_valid=1.
- RESP: rsp_valid, rsp_hit and rsp_tag hold stable until rsp_ready. On a handshake, next state is IDLE and rsp_valid=0.
- Only one CHECK is outstanding at a time. No commands are accepted in WAIT_MATCH or RESP.
- An INSERT/CHECK to the same key spaced by at least INS_LAT is guaranteed to hit.
- Synchronous reset in any state returns to IDLE in the next cycle and suppresses any bl_* pulse.

Optional Feature:
- Macro BLOOM_SEQ_STATS_EN.
- Defined: stat_ins increments on INSERT accept, stat_chk on CHECK accept, stat_hit on a RESP entry with hit=1. Counters saturate at all-ones, are cleared only by reset, and are unaffected by CLEAR.
- Undefined: stat_* ports remain and are tied to 0; no counter flops are built.

Decomposition:
- Package bloom_seq_pkg holds the op enum (NOP/INSERT/CHECK/CLEAR, 2 bits) and the state enum (IDLE/WAIT_MATCH/RESP).
- One natural sub-module, bloom_seq_sat_cnt: a parameterised saturating counter with inc and sync reset, instantiated three times under the macro.

Test Plan:
- INSERT key 0xDEADBEEF at T, then CHECK same key tag 3 -> bl_insert pulse at T+1; cmd_ready low for CHECK until haz_cnt 0; rsp_valid with hit=1, tag=3; bl_match sampled exactly MATCH_LAT after bl_check.
- After reset, CHECK 0x12345678 tag 5 with bl_match=0 -> rsp_hit=0, rsp_tag=5; stat_chk=1, stat_hit=0.
- Three back-to-back INSERTs with valid held -> three consecutive bl_insert pulses with matching bl_data; cmd_ready stays 1; stat_ins=3.
- CLEAR then CHECK -> bl_reset pulse one cycle after accept; CHECK delayed INS_LAT cycles; prior key now misses.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/hit/tag stable, cmd_ready=0 throughout; IDLE one cycle after handshake.
- Reset asserted in WAIT_MATCH -> no response issued, all outputs 0 next cycle, stats zero; with the macro on, stat counters forced near max saturate at 0xFFFF.

Source files
------------

// File: rtl/bloom_seq_pkg.sv
// Shared types for the Bloom filter request sequencer.
//   op_e    : command opcode carried on cmd_op
//   state_e : sequencer FSM states
package bloom_seq_pkg;

    typedef enum logic [1:0] {
        OpNop    = 2'b00,
        OpInsert = 2'b01,
        OpCheck  = 2'b10,
        OpClear  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StWaitMatch = 2'b01,
        StResp      = 2'b10
    } state_e;

    // Ops that modify filter contents and so open a hazard window for CHECK.
    function automatic logic is_write_op(input op_e op);
        return (op == OpInsert) || (op == OpClear);
    endfunction

endpackage

// File: rtl/bloom_seq_sat_cnt.sv
// Saturating up-counter used for sequencer statistics.
// Ports:
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : increment request (ignored once the counter is all-ones)
//   count : current count
module bloom_seq_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bloom_req_sequencer.sv
// Command front end for the Bloom filter. Accepts NOP/INSERT/CHECK/CLEAR commands
// over valid/ready, drives registered one-cycle pulses on the filter pins, holds off
// CHECK while a recent INSERT/CLEAR is still in the hash pipeline, and returns the
// sampled match as a tagged valid/ready response. One CHECK is outstanding at a time.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   cmd_valid/ready/op/key/tag       : command stream
//   bl_insert/check/reset/data       : registered filter drive
//   bl_match                         : filter match result
//   rsp_valid/ready/hit/tag          : response stream
//   stat_ins/chk/hit                 : statistics counters
// Build option: define BLOOM_SEQ_STATS_EN to build the statistics counters;
// otherwise the stat_* ports are tied to zero.
module bloom_req_sequencer
    import bloom_seq_pkg::*;
#(
    parameter int unsigned D_SIZE    = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned INS_LAT   = 2,
    parameter int unsigned MATCH_LAT = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [D_SIZE-1:0] cmd_key,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              bl_insert,
    output logic              bl_check,
    output logic              bl_reset,
    output logic [D_SIZE-1:0] bl_data,
    input  logic              bl_match,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [CNT_W-1:0]  stat_ins,
    output logic [CNT_W-1:0]  stat_chk,
    output logic [CNT_W-1:0]  stat_hit
);

    // +2 keeps the width at least one bit even for a zero latency.
    localparam int unsigned HAZ_W  = $clog2(INS_LAT + 2);
    localparam int unsigned WCNT_W = $clog2(MATCH_LAT + 2);

    state_e              state_q;
    logic [HAZ_W-1:0]    haz_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                bl_insert_q, bl_check_q, bl_reset_q;
    logic [D_SIZE-1:0]   bl_data_q;
    logic                rsp_valid_q, rsp_hit_q;
    logic [TAG_W-1:0]    rsp_tag_q;

    op_e  op;
    logic accept;
    logic match_sample;

    assign op = op_e'(cmd_op);

    // Only CHECK is stalled by the hazard window; writes and NOPs flow freely.
    assign cmd_ready    = !reset && (state_q == StIdle) && ((haz_q == '0) || (op != OpCheck));
    assign accept       = cmd_valid && cmd_ready;
    assign match_sample = (state_q == StWaitMatch) && (wcnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            haz_q       <= '0;
            wcnt_q      <= '0;
            bl_insert_q <= 1'b0;
            bl_check_q  <= 1'b0;
            bl_reset_q  <= 1'b0;
            bl_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            bl_insert_q <= accept && (op == OpInsert);
            bl_check_q  <= accept && (op == OpCheck);
            bl_reset_q  <= accept && (op == OpClear);
            if (accept) begin
                bl_data_q <= cmd_key;
            end

            // A fresh write restarts the window even if it was still counting.
            if (accept && is_write_op(op)) begin
                haz_q <= HAZ_W'(INS_LAT);
            end else if (haz_q != '0) begin
                haz_q <= haz_q - HAZ_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (accept && (op == OpCheck)) begin
                        state_q   <= StWaitMatch;
                        wcnt_q    <= WCNT_W'(MATCH_LAT);
                        rsp_tag_q <= cmd_tag;
                    end
                end
                StWaitMatch: begin
                    // wcnt reaches zero MATCH_LAT cycles after the bl_check pulse.
                    if (wcnt_q == '0) begin
                        rsp_hit_q   <= bl_match;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bl_insert = bl_insert_q;
    assign bl_check  = bl_check_q;
    assign bl_reset  = bl_reset_q;
    assign bl_data   = bl_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_tag   = rsp_tag_q;

`ifdef BLOOM_SEQ_STATS_EN
    logic inc_ins, inc_chk, inc_hit;

    assign inc_ins = accept && (op == OpInsert);
    assign inc_chk = accept && (op == OpCheck);
    assign inc_hit = match_sample && bl_match;

    bloom_seq_sat_cnt #(.W(CNT_W)) u_cnt_ins (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_ins),
        .count (stat_ins)
    );

    bloom_seq_sat_cnt #(.W(CNT_W)) u_cnt_chk (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_chk),
        .count (stat_chk)
    );

    bloom_seq_sat_cnt #(.W(CNT_W)) u_cnt_hit (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_hit),
        .count (stat_hit)
    );
`else
    logic unused_match_sample;
    assign unused_match_sample = match_sample;
    assign stat_ins = '0;
    assign stat_chk = '0;
    assign stat_hit = '0;
`endif

endmodule
